// File: rtl/cdu_read_counter.sv
// cdu_read_counter: digital closing half of the CDU fine error loop.
// It synchronizes the ternary level flags from the main summing amplifier,
// steps an up/down read counter toward null at a mode-dependent rate, emits
// one-cycle up/down count pulses toward the AGC interface, and drives the
// active-low ladder switch lines _D15.._D21.
// Optional build macro: CDU_ZERO_EN adds the synchronous zero_cdu input.

module cdu_read_counter #(
  parameter int WIDTH        = 16,
  parameter int FINE_DIV     = 4,
  parameter int COARSE_DIV   = 2,
  parameter int COARSE_SHIFT = 3
) (
  input  logic             clk,
  input  logic             rst_n,
`ifdef CDU_ZERO_EN
  input  logic             zero_cdu,
`endif
  input  logic             _TLF1H,
  input  logic             _TLF1L,
  input  logic             _TLF2H,
  input  logic             _TLF2L,
  output logic [WIDTH-1:0] count,
  output logic             _D15,
  output logic             _D16,
  output logic             _D17,
  output logic             _D18,
  output logic             _D19,
  output logic             _D20,
  output logic             _D21,
  output logic             up_pulse,
  output logic             dn_pulse,
  output logic [1:0]       mode,
  output logic             conflict
);

  typedef enum logic [1:0] {
    MODE_IDLE   = 2'd0,
    MODE_FINE   = 2'd1,
    MODE_COARSE = 2'd2
  } mode_e;

  localparam int MAX_DIV = (FINE_DIV > COARSE_DIV) ? FINE_DIV : COARSE_DIV;
  localparam int TW      = (MAX_DIV > 1) ? $clog2(MAX_DIV) : 1;

  localparam logic [TW-1:0]    FINE_LAST   = TW'(FINE_DIV - 1);
  localparam logic [TW-1:0]    COARSE_LAST = TW'(COARSE_DIV - 1);
  localparam logic [WIDTH-1:0] FINE_STEP   = WIDTH'(1);
  localparam logic [WIDTH-1:0] COARSE_STEP = WIDTH'(1) << COARSE_SHIFT;

  // Flag vector ordering used throughout: {1H, 1L, 2H, 2L}
  logic [3:0]       sync1_q, sync1_d;
  logic [3:0]       sync2_q, sync2_d;
  mode_e            mode_q, mode_d;
  logic             dir_q, dir_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             up_q, up_d;
  logic             dn_q, dn_d;
  logic             conflict_q, conflict_d;

  logic             l1_pos, l1_neg, l2_pos, l2_neg;
  logic             zero_req;
  logic [TW-1:0]    div_last;
  logic [WIDTH-1:0] step_amt;

`ifdef CDU_ZERO_EN
  assign zero_req = zero_cdu;
`else
  assign zero_req = 1'b0;
`endif

  // Two-flop synchronizer chain for the asynchronous level flags
  always_comb begin
    sync1_d = {_TLF1H, _TLF1L, _TLF2H, _TLF2L};
    sync2_d = sync1_q;
  end

  // Per-level decode; opposing flags both set count as no error at that level
  always_comb begin
    l1_pos     = sync2_q[3] & ~sync2_q[2];
    l1_neg     = sync2_q[2] & ~sync2_q[3];
    l2_pos     = sync2_q[1] & ~sync2_q[0];
    l2_neg     = sync2_q[0] & ~sync2_q[1];
    conflict_d = (sync2_q[3] & sync2_q[2]) | (sync2_q[1] & sync2_q[0]);
  end

  // Next-state: coarse error wins over fine, direction from the winning level
  always_comb begin
    mode_d = MODE_IDLE;
    dir_d  = 1'b0;
    if (l2_pos || l2_neg) begin
      mode_d = MODE_COARSE;
      dir_d  = l2_pos;
    end else if (l1_pos || l1_neg) begin
      mode_d = MODE_FINE;
      dir_d  = l1_pos;
    end
    if (zero_req) begin
      mode_d = MODE_IDLE;
      dir_d  = 1'b0;
    end
  end

  // Rate timer and counter step; a mode or direction change abandons the interval
  always_comb begin
    timer_d  = '0;
    count_d  = count_q;
    up_d     = 1'b0;
    dn_d     = 1'b0;
    div_last = (mode_q == MODE_COARSE) ? COARSE_LAST : FINE_LAST;
    step_amt = (mode_q == MODE_COARSE) ? COARSE_STEP : FINE_STEP;
    if ((mode_q != MODE_IDLE) && (mode_d == mode_q) && (dir_d == dir_q)) begin
      if (timer_q == div_last) begin
        timer_d = '0;
        if (dir_q) begin
          count_d = count_q + step_amt;
          up_d    = 1'b1;
        end else begin
          count_d = count_q - step_amt;
          dn_d    = 1'b1;
        end
      end else begin
        timer_d = timer_q + 1'b1;
      end
    end
    if (zero_req) begin
      count_d = '0;
      timer_d = '0;
      up_d    = 1'b0;
      dn_d    = 1'b0;
    end
  end

  // State register with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      mode_q     <= MODE_IDLE;
      dir_q      <= 1'b0;
      timer_q    <= '0;
      count_q    <= '0;
      up_q       <= 1'b0;
      dn_q       <= 1'b0;
      conflict_q <= 1'b0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      mode_q     <= mode_d;
      dir_q      <= dir_d;
      timer_q    <= timer_d;
      count_q    <= count_d;
      up_q       <= up_d;
      dn_q       <= dn_d;
      conflict_q <= conflict_d;
    end
  end

  // Outputs: registered values, ladder lines are inversions of count bits
  always_comb begin
    count    = count_q;
    mode     = mode_q;
    up_pulse = up_q;
    dn_pulse = dn_q;
    conflict = conflict_q;
    _D15     = ~count_q[6];
    _D16     = ~count_q[5];
    _D17     = ~count_q[4];
    _D18     = ~count_q[3];
    _D19     = ~count_q[2];
    _D20     = ~count_q[1];
    _D21     = ~count_q[0];
  end

endmodule

// File: doc/cdu_read_counter.md
Name: cdu_read_counter

Overview:
- Digital closing half of the CDU fine error loop.
- Samples the main-summing-amplifier ternary level flags: fine-threshold flags _TLF1H/_TLF1L and coarse-threshold flags _TLF2H/_TLF2L.
- Steps an up/down read counter toward null and emits one-cycle up/down count pulses toward the AGC interface.
- Drives the active-low ladder switch lines _D15.._D21 that feed back into the ladder amplifier.

Parameters:
- WIDTH, 16, read counter width (min 8).
- FINE_DIV, 4, clocks between steps in FINE mode (>=1).
- COARSE_DIV, 2, clocks between steps in COARSE mode (>=1).
- COARSE_SHIFT, 3, coarse step size = 1<<COARSE_SHIFT LSBs (< WIDTH).

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; asynchronous assert, active-low
- _TLF1H  in  1  fine flag, positive error, active-high, asynchronous
- _TLF1L  in  1  fine flag, negative error, active-high, asynchronous
- _TLF2H  in  1  coarse flag, positive error, active-high, asynchronous
- _TLF2L  in  1  coarse flag, negative error, active-high, asynchronous
- count  out  WIDTH  read counter value
- _D15.._D21  out  1 each  ladder switches, active-low; _D15=~count[6] ... _D21=~count[0]
- up_pulse  out  1  one-cycle pulse per increment step
- dn_pulse  out  1  one-cycle pulse per decrement step
- mode  out  2  0=IDLE, 1=FINE, 2=COARSE
- conflict  out  1  high while opposing flags of the same level are both set

Behaviour:
- Reset (async, rst_n=0):
  - count=0, so _D15.._D21 all 1.
  - mode=IDLE; up_pulse=dn_pulse=0; conflict=0.
  - Synchronizers and rate timer cleared.
- Input synchronization: each flag passes through a 2-flop synchronizer. Everything below uses synchronized values only.
- Per-level decode: pos = xH & ~xL; neg = xL & ~xH; both set = conflict at that level, treated as no error for that level.
  - conflict is registered: (s1H&s1L)|(s2H&s2L).
- Next-state priority:
  - COARSE if level-2 pos or neg.
  - Else FINE if level-1 pos or neg.
  - Else IDLE.
  - Direction comes from the same level that selected the mode.
- Registered state: mode updates on the clock edge after the synchronized change. Pin change to mode change = 3 edges.
- Rate timer:
  - Clears on any mode change or direction change.
  - Counts 0..DIV-1 while in FINE/COARSE.
  - At timer==DIV-1 a step fires and the timer wraps to 0.
  - First step therefore lands DIV edges after state entry.
  - With DIV=1, a step fires every clock.
- Step:
  - FINE: count ±1.
  - COARSE: count ±(1<<COARSE_SHIFT).
  - Arithmetic is modulo 2^WIDTH; wrap in both directions is silent.
  - up_pulse or dn_pulse is high on the same edge that count changes, for exactly one cycle.
  - Up and down pulses are never both high.
- IDLE: count holds, no pulses, timer held at 0.
- Flags dropping mid-interval: the pending step is abandoned, no partial step.
- Conflict at level 2 with a valid level-1 error: FINE mode runs using the level-1 direction.
- Ladder outputs are combinational inversions of registered count bits, so they are glitch-free relative to clk.
- Reset asserted mid-count: immediate return to reset values. After release, operation restarts with the synchronizer refilling (2 edges).

Optional Feature:
- Macro CDU_ZERO_EN.
- When defined:
  - Adds input zero_cdu (active-high, synchronous).
  - While zero_cdu=1: count forced to 0, mode forced IDLE, timer cleared, pulses suppressed.
  - Counting resumes on the first edge after deassertion, subject to normal flag decode.
- When undefined: the port is absent and the logic is removed; behaviour is otherwise identical.

Test Plan:
- Reset: rst_n=0 with random flags -> count=0, all _D15.._D21=1, mode=0, no pulses; rst_n=1 with flags low -> unchanged for 50 clocks.
- Fine up (FINE_DIV=4): hold _TLF1H=1 -> mode=1 at edge 3; after 20 further clocks count=5, up_pulse fired 5 times; _D21=0, _D19=0, others 1.
- Coarse down with wrap (COARSE_DIV=2, COARSE_SHIFT=3): from count=0, hold _TLF2L=1 plus _TLF1L=1 -> mode=2; after 4 entry clocks count=16'hFFF0 with 2 dn_pulses.
- Priority/hand-over: coarse positive, then drop _TLF2H keeping _TLF1H -> mode 2->1, timer restarts, next step is +1 after exactly 4 clocks.
- Conflict: _TLF1H=_TLF1L=1 -> conflict=1, mode=0, count frozen. Add _TLF2H=1 -> COARSE up with conflict still 1.
- CDU_ZERO_EN build: count=0x1234 while counting, pulse zero_cdu 1 clock -> next edge count=0, mode=0. Counting resumes afterward.
